// File: rtl/mac_row_ctrl_pkg.sv
// Shared definitions for the FP16 MAC row sequencer: FSM states, default lane
// count and accumulator-source select encodings.
package mac_row_ctrl_pkg;

    localparam int unsigned NUM_PE_DEF = 4;

    localparam logic ACC_SRC_BIAS = 1'b0;
    localparam logic ACC_SRC_FB   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mac_skew_pipe.sv
// Delay line of DEPTH stages, WIDTH bits each; tap j is the input delayed j+1 cycles.
module mac_skew_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [DEPTH*WIDTH-1:0] taps_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (flush_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din_i;
            for (int unsigned j = 1; j < DEPTH; j++) begin
                stage_q[j] <= stage_q[j-1];
            end
        end
    end

    assign taps_o = stage_q;

endmodule

// File: rtl/mac_row_ctrl.sv
// K-step dot-product sequencer for a row of FP16 MAC PEs with one-cycle-per-lane
// systolic skew of every enable field.
module mac_row_ctrl
    import mac_row_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PE = NUM_PE_DEF,
    parameter int unsigned K_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic              abort,
    input  logic              op_valid,
    output logic              op_ready,
    output logic [NUM_PE-1:0] ld_en,
    output logic [NUM_PE-1:0] add_sel,
    output logic [NUM_PE-1:0] mul_en,
    output logic [NUM_PE-1:0] add_en,
    output logic              busy,
    output logic              done,
    output logic [K_W-1:0]    step_cnt
);

    localparam int unsigned DW = (NUM_PE > 2) ? $clog2(NUM_PE - 1) : 1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(NUM_PE - 2);
    localparam logic [K_W-1:0] STEP_ONE   = K_W'(1);

    state_t         state_q;
    logic [K_W-1:0] step_cnt_q;
    logic [K_W-1:0] k_len_q;
    logic [DW-1:0]  drain_cnt_q;
    logic           busy_q;
    logic           done_q;

    logic ld0, sel0, mul0, add0;
    logic [NUM_PE-2:0] ld_tap, sel_tap, mul_tap, add_tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_cnt_q  <= '0;
            k_len_q     <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort) begin
            // Also covers IDLE, so start+abort there is dropped.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (k_len != '0) begin
                            k_len_q    <= k_len;
                            step_cnt_q <= '0;
                            state_q    <= S_LOAD;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (op_valid) state_q <= S_EXEC;
                end
                S_EXEC: begin
                    step_cnt_q <= step_cnt_q + STEP_ONE;
                    if (step_cnt_q + STEP_ONE == k_len_q) begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= '0;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_DRAIN: begin
                    // Last lane's final add_en issues NUM_PE-1 cycles after lane 0's.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ld0  = (state_q == S_LOAD) && op_valid;
    assign sel0 = (ld0 && (step_cnt_q != '0)) ? ACC_SRC_FB : ACC_SRC_BIAS;
    assign mul0 = (state_q == S_EXEC);
    assign add0 = (state_q == S_EXEC);

    mac_skew_pipe #(.WIDTH(1), .DEPTH(NUM_PE - 1)) u_ld_pipe (
        .clk(clk), .rst(rst), .flush_i(abort), .din_i(ld0), .taps_o(ld_tap)
    );
    mac_skew_pipe #(.WIDTH(1), .DEPTH(NUM_PE - 1)) u_sel_pipe (
        .clk(clk), .rst(rst), .flush_i(abort), .din_i(sel0), .taps_o(sel_tap)
    );
    mac_skew_pipe #(.WIDTH(1), .DEPTH(NUM_PE - 1)) u_mul_pipe (
        .clk(clk), .rst(rst), .flush_i(abort), .din_i(mul0), .taps_o(mul_tap)
    );
    mac_skew_pipe #(.WIDTH(1), .DEPTH(NUM_PE - 1)) u_add_pipe (
        .clk(clk), .rst(rst), .flush_i(abort), .din_i(add0), .taps_o(add_tap)
    );

    assign ld_en    = {ld_tap, ld0};
    assign add_sel  = {sel_tap, sel0};
    assign mul_en   = {mul_tap, mul0};
    assign add_en   = {add_tap, add0};
    assign op_ready = (state_q == S_LOAD);
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_mac_row_ctrl.sv
// Directed bench for mac_row_ctrl: per-cycle lane enable patterns against
// hand-derived tables for normal, stalled, zero-length, aborted and reset jobs.
module tb_mac_row_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] k_len;
    logic       abort;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] ld_en, add_sel, mul_en, add_en;
    logic       busy, done;
    logic [7:0] step_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    mac_row_ctrl #(.NUM_PE(4), .K_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .ld_en(ld_en), .add_sel(add_sel),
        .mul_en(mul_en), .add_en(add_en), .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // K=2, op_valid=1: cycles c0..c9; bdr = {busy, done, op_ready}
    logic [3:0] t1_ld  [10] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] t1_sel [10] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] t1_mul [10] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h0};
    logic [2:0] t1_bdr [10] = '{3'd0, 3'd5, 3'd4, 3'd5, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6, 3'd0};

    // K=3, op_valid low in c3,c4: cycles c0..c13
    logic [3:0] t2_ld  [14] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] t2_sel [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] t2_mul [14] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h0};
    logic [2:0] t2_bdr [14] = '{3'd0, 3'd5, 3'd4, 3'd5, 3'd5, 3'd5, 3'd4, 3'd5, 3'd4, 3'd4, 3'd4, 3'd4, 3'd6, 3'd0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [3:0] eld, input logic [3:0] esel,
                              input logic [3:0] emul, input logic [2:0] ebdr);
        check_val({tag, " ld_en"},   32'(ld_en),   32'(eld));
        check_val({tag, " add_sel"}, 32'(add_sel), 32'(esel));
        check_val({tag, " mul_en"},  32'(mul_en),  32'(emul));
        check_val({tag, " add_en"},  32'(add_en),  32'(emul));
        check_val({tag, " bsy/dn/rdy"}, 32'({busy, done, op_ready}), 32'(ebdr));
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; abort = 1'b0; op_valid = 1'b0;
        #12;
        expect_cyc("in_reset", 4'h0, 4'h0, 4'h0, 3'd0);
        check_val("in_reset step_cnt", 32'(step_cnt), 32'd0);
        next_cyc(); rst = 1'b0;
        next_cyc(); #2;
        expect_cyc("post_reset", 4'h0, 4'h0, 4'h0, 3'd0);

        // Test 1: K=2 with operands always valid
        next_cyc(); start = 1'b1; k_len = 8'd2; op_valid = 1'b1; #2;
        expect_cyc("t1 c0", t1_ld[0], t1_sel[0], t1_mul[0], t1_bdr[0]);
        for (int c = 1; c < 10; c++) begin
            next_cyc(); start = 1'b0; #2;
            expect_cyc($sformatf("t1 c%0d", c), t1_ld[c], t1_sel[c], t1_mul[c], t1_bdr[c]);
            if (c == 3) check_val("t1 c3 step_cnt", 32'(step_cnt), 32'd1);
        end
        check_val("t1 final step_cnt", 32'(step_cnt), 32'd2);

        // Test 2: K=3 with a 2-cycle operand stall before step 2
        next_cyc(); start = 1'b1; k_len = 8'd3; #2;
        expect_cyc("t2 c0", t2_ld[0], t2_sel[0], t2_mul[0], t2_bdr[0]);
        for (int c = 1; c < 14; c++) begin
            next_cyc(); start = 1'b0; op_valid = (c == 3 || c == 4) ? 1'b0 : 1'b1; #2;
            expect_cyc($sformatf("t2 c%0d", c), t2_ld[c], t2_sel[c], t2_mul[c], t2_bdr[c]);
        end
        check_val("t2 final step_cnt", 32'(step_cnt), 32'd3);

        // Test 3: zero-length job
        next_cyc(); start = 1'b1; k_len = 8'd0; op_valid = 1'b1; #2;
        expect_cyc("t3 c0", 4'h0, 4'h0, 4'h0, 3'd0);
        next_cyc(); start = 1'b0; #2;
        expect_cyc("t3 c1", 4'h0, 4'h0, 4'h0, 3'd6);
        for (int c = 2; c < 4; c++) begin
            next_cyc(); #2;
            expect_cyc($sformatf("t3 c%0d", c), 4'h0, 4'h0, 4'h0, 3'd0);
        end

        // Test 4: abort in DRAIN of a K=4 job, then an immediate K=1 job
        next_cyc(); start = 1'b1; k_len = 8'd4; #2;
        for (int c = 1; c < 11; c++) begin
            next_cyc(); start = 1'b0; abort = (c == 10); #2;
            if (c == 9)  expect_cyc("t4 c9",  4'h4, 4'h4, 4'hA, 3'd4);
            if (c == 10) expect_cyc("t4 c10", 4'h8, 4'h8, 4'h4, 3'd4);
        end
        next_cyc(); abort = 1'b0; start = 1'b1; k_len = 8'd1; #2;
        expect_cyc("t4 c11 flushed", 4'h0, 4'h0, 4'h0, 3'd0);
        check_val("t4 c11 step_cnt", 32'(step_cnt), 32'd4);
        next_cyc(); start = 1'b0; #2;
        expect_cyc("t4 c12 restart", 4'h1, 4'h0, 4'h0, 3'd5);
        for (int c = 13; c < 18; c++) begin
            next_cyc(); #2;
            check_val($sformatf("t4 c%0d bsy/dn", c), 32'({busy, done}), (c == 17) ? 32'd3 : 32'd2);
            if (c == 13) check_val("t4 c13 mul_en", 32'(mul_en), 32'h1);
            if (c == 16) check_val("t4 c16 add_en", 32'(add_en), 32'h8);
        end
        check_val("t4 c17 step_cnt", 32'(step_cnt), 32'd1);

        // Test 5: start while busy, then start+abort in IDLE
        next_cyc(); start = 1'b1; k_len = 8'd2; #2;
        expect_cyc("t5 c0", t1_ld[0], t1_sel[0], t1_mul[0], t1_bdr[0]);
        for (int c = 1; c < 10; c++) begin
            next_cyc(); start = (c == 2 || c == 3); k_len = (c == 2 || c == 3) ? 8'd5 : 8'd2; #2;
            expect_cyc($sformatf("t5 c%0d", c), t1_ld[c], t1_sel[c], t1_mul[c], t1_bdr[c]);
        end
        check_val("t5 c9 step_cnt", 32'(step_cnt), 32'd2);
        next_cyc(); start = 1'b1; abort = 1'b1; k_len = 8'd3; #2;
        expect_cyc("t5 c10", 4'h0, 4'h0, 4'h0, 3'd0);
        next_cyc(); start = 1'b0; abort = 1'b0; #2;
        expect_cyc("t5 c11 ignored", 4'h0, 4'h0, 4'h0, 3'd0);
        check_val("t5 c11 step_cnt", 32'(step_cnt), 32'd2);

        // Test 6: asynchronous reset in the middle of EXEC
        next_cyc(); start = 1'b1; k_len = 8'd3; #2;
        for (int c = 1; c < 5; c++) begin
            next_cyc(); start = 1'b0; #2;
        end
        expect_cyc("t6 c4 pre_rst", 4'hA, 4'h2, 4'h5, 3'd4);
        #1 rst = 1'b1;
        #1;
        expect_cyc("t6 async_rst", 4'h0, 4'h0, 4'h0, 3'd0);
        check_val("t6 async_rst step_cnt", 32'(step_cnt), 32'd0);
        #3 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cyc(); #2;
            expect_cyc($sformatf("t6 idle%0d", c), 4'h0, 4'h0, 4'h0, 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
